// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - handshake and memory bus bundle between the program loader and its neighbours
// Purpose: groups the loader's control, byte-source, memory and core-control signals.
// Ports (master = loader side):
//   start        in   load request, level sampled
//   src_valid    in   source byte available
//   src_data     in   source byte
//   src_ready    out  loader accepts a byte this cycle
//   mem_addr     out  memory address (registered)
//   mem_din      out  memory write data (registered)
//   mem_we       out  memory write enable (registered)
//   mem_dout     in   memory read data, valid one cycle after mem_addr
//   core_reset_n out  active-low reset to fetcher/decoder/ALU/registers
//   trigger      out  one-cycle start pulse to the fetcher
//   busy/done/error out  status
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  start;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  core_reset_n;
  logic                  trigger;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    input  start, src_valid, src_data, mem_dout,
    output src_ready, mem_addr, mem_din, mem_we, core_reset_n, trigger, busy, done, error
  );

  modport slave (
    output start, src_valid, src_data, mem_dout,
    input  src_ready, mem_addr, mem_din, mem_we, core_reset_n, trigger, busy, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a fixed-length byte image into program memory, then releases the core
// Purpose: while the core is held in reset, copies LENGTH bytes from a valid/ready byte source into
//   memory starting at BASE_ADDR (address wraps modulo 2^ADDR_WIDTH), optionally reads the image back
//   and compares checksums, then raises core_reset_n and pulses trigger once.
// Build option: define PROG_LOADER_VERIFY_EN to build the read-back verify (VERIFY/CHECK states,
//   rsum accumulator, ERROR path). Without it LOAD goes straight to RELEASE and error stays 0.
// Ports:
//   clk    in  memory clock
//   reset  in  asynchronous active-high reset
//   bus    prog_loader_if.master (start, src_*, mem_*, core_reset_n, trigger, busy, done, error)
module prog_loader #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  // Platform memory map: instruction region starts at 0x0100 and runs to the top of memory.
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'('h0100),
  parameter int                    LENGTH     = 65280
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, CHECK, RELEASE, RUN, ERROR} state_t;

  // cnt must reach LENGTH during verify (LENGTH issue cycles plus one drain cycle).
  localparam int               CNT_W = $clog2(LENGTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LENGTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             enter_load;

`ifdef PROG_LOADER_VERIFY_EN
  localparam logic [CNT_W-1:0] FULL = CNT_W'(LENGTH);
  logic [DATA_WIDTH-1:0] wsum;
  logic [DATA_WIDTH-1:0] rsum;
`endif

  // start is honoured only when no load/verify/release sequence is in flight.
  assign enter_load = bus.start && (state == IDLE || state == RUN || state == ERROR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      bus.src_ready    <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_din      <= '0;
      bus.mem_we       <= 1'b0;
      bus.core_reset_n <= 1'b0;
      bus.trigger      <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.error        <= 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
      wsum             <= '0;
      rsum             <= '0;
`endif
    end else begin
      // Write enable and trigger are single-cycle strobes unless re-asserted below.
      bus.mem_we  <= 1'b0;
      bus.trigger <= 1'b0;
      if (enter_load) begin
        state            <= LOAD;
        cnt              <= '0;
        bus.src_ready    <= 1'b1;
        bus.core_reset_n <= 1'b0;
        bus.busy         <= 1'b1;
        bus.done         <= 1'b0;
        bus.error        <= 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
        wsum             <= '0;
`endif
      end else begin
        case (state)
          LOAD: begin
            if (bus.src_valid && bus.src_ready) begin
              bus.mem_addr <= BASE_ADDR + ADDR_WIDTH'(cnt);
              bus.mem_din  <= bus.src_data;
              bus.mem_we   <= 1'b1;
              cnt          <= cnt + 1'b1;
`ifdef PROG_LOADER_VERIFY_EN
              wsum         <= wsum + bus.src_data;
`endif
              if (cnt == LAST) begin
                bus.src_ready <= 1'b0;
`ifdef PROG_LOADER_VERIFY_EN
                state <= VERIFY;
                cnt   <= '0;
                rsum  <= '0;
`else
                state            <= RELEASE;
                bus.core_reset_n <= 1'b1;
`endif
              end
            end
          end
`ifdef PROG_LOADER_VERIFY_EN
          // Cycle cnt issues read address cnt and accumulates the data for address cnt-1.
          // The first cycle carries the final write, so its read data is discarded.
          VERIFY: begin
            if (cnt != FULL) begin
              bus.mem_addr <= BASE_ADDR + ADDR_WIDTH'(cnt);
            end
            if (cnt != '0) begin
              rsum <= rsum + bus.mem_dout;
            end
            if (cnt == FULL) begin
              state <= CHECK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          CHECK: begin
            if (rsum == wsum) begin
              state            <= RELEASE;
              bus.core_reset_n <= 1'b1;
            end else begin
              state     <= ERROR;
              bus.error <= 1'b1;
              bus.busy  <= 1'b0;
            end
          end
`endif
          RELEASE: begin
            state       <= RUN;
            bus.trigger <= 1'b1;
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
          end
          default: begin
            // IDLE, RUN and ERROR hold until start.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader against a memory-image model
module tb_prog_loader;

  localparam int          L      = 4;
  localparam logic [15:0] BASE_A = 16'h0010;
  localparam logic [15:0] BASE_B = 16'hFFFE;
`ifdef PROG_LOADER_VERIFY_EN
  localparam bit          VERIFY = 1'b1;
`else
  localparam bit          VERIFY = 1'b0;
`endif
  // Cycles from the start-asserting cycle to the first cycle trigger is seen.
  localparam int          T_TRIG = VERIFY ? (2 * L + 4) : (L + 2);

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       src_valid;
  logic [7:0] src_data;
  logic       sel;
  logic       corrupt;
  logic [7:0] mem [0:65535];
  logic [7:0] img [L];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          trig_cnt = 0;
  logic [15:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_a ();
  prog_loader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus_b ();

  prog_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(BASE_A), .LENGTH(L)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  prog_loader #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .BASE_ADDR(BASE_B), .LENGTH(L)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  assign bus_a.start     = start & ~sel;
  assign bus_a.src_valid = src_valid & ~sel;
  assign bus_a.src_data  = src_data;
  assign bus_a.mem_dout  = mem[bus_a.mem_addr];
  assign bus_b.start     = start & sel;
  assign bus_b.src_valid = src_valid & sel;
  assign bus_b.src_data  = src_data;
  assign bus_b.mem_dout  = mem[bus_b.mem_addr];

  logic        o_ready, o_we, o_crn, o_trig, o_busy, o_done, o_err;
  logic [15:0] o_addr;
  logic [7:0]  o_din;
  assign o_ready = sel ? bus_b.src_ready    : bus_a.src_ready;
  assign o_we    = sel ? bus_b.mem_we       : bus_a.mem_we;
  assign o_crn   = sel ? bus_b.core_reset_n : bus_a.core_reset_n;
  assign o_trig  = sel ? bus_b.trigger      : bus_a.trigger;
  assign o_busy  = sel ? bus_b.busy         : bus_a.busy;
  assign o_done  = sel ? bus_b.done         : bus_a.done;
  assign o_err   = sel ? bus_b.error        : bus_a.error;
  assign o_addr  = sel ? bus_b.mem_addr     : bus_a.mem_addr;
  assign o_din   = sel ? bus_b.mem_din      : bus_a.mem_din;

  // Memory with combinational read; while corrupt is set, loader A's write to 0x12 stores 0x00.
  always @(posedge clk) begin
    if (bus_a.mem_we)
      mem[bus_a.mem_addr] <= (corrupt && bus_a.mem_addr == 16'h0012) ? 8'h00 : bus_a.mem_din;
    if (bus_b.mem_we)
      mem[bus_b.mem_addr] <= bus_b.mem_din;
    if (o_we) begin
      wr_addr_q.push_back(o_addr);
      wr_data_q.push_back(o_din);
    end
    if (o_trig) trig_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic rand_img();
    for (int j = 0; j < L; j++) img[j] = 8'($urandom);
  endtask

  // mode 0: src_valid held high, 1: alternating, 2: random gaps. noisy adds start pulses during LOAD.
  task automatic run_load(input int mode, input bit noisy, input string tag);
    int          i, k, t0, trig0, s_img, s_mem;
    bit          hs, exp_err;
    logic [15:0] base, a;
    logic [7:0]  exp_mem [L];
    base  = sel ? BASE_B : BASE_A;
    s_img = 0;
    s_mem = 0;
    for (int j = 0; j < L; j++) begin
      a          = 16'(base + 16'(j));
      exp_mem[j] = (corrupt && !sel && a == 16'h0012) ? 8'h00 : img[j];
      s_img     += int'(img[j]);
      s_mem     += int'(exp_mem[j]);
    end
    exp_err = VERIFY && ((s_img % 256) != (s_mem % 256));
    trig0   = trig_cnt;
    wr_addr_q.delete();
    wr_data_q.delete();
    i = 0; k = 0; t0 = -1; hs = 1'b0;
    start     = 1'b1;
    src_valid = 1'b1;
    src_data  = img[0];
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (hs) i++;
      if (k == 1) check({tag, "_enter"}, {o_crn, o_ready, o_busy, o_done, o_err}, 5'b01100);
      if (o_trig || o_err) begin
        t0 = k;
        break;
      end
      start = (noisy && i < L) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (i < L) begin
        case (mode)
          0:       src_valid = 1'b1;
          1:       src_valid = ~src_valid;
          default: src_valid = 1'($urandom_range(0, 1));
        endcase
        src_data = img[i];
      end else begin
        src_valid = 1'($urandom_range(0, 1));
        src_data  = 8'($urandom);
      end
      hs = src_valid && o_ready;
    end
    start     = 1'b0;
    src_valid = 1'b0;
    check({tag, "_end"}, t0 > 0, 1'b1);
    check({tag, "_nwr"}, wr_addr_q.size(), L);
    for (int j = 0; j < L && j < wr_addr_q.size(); j++) begin
      check({tag, "_waddr"}, wr_addr_q[j], 16'(base + 16'(j)));
      check({tag, "_wdata"}, wr_data_q[j], img[j]);
    end
    for (int j = 0; j < L; j++)
      check({tag, "_mem"}, mem[16'(base + 16'(j))], exp_mem[j]);
    if (exp_err) begin
      check({tag, "_errst"}, {o_err, o_crn, o_done, o_busy}, 4'b1000);
      repeat (3) @(negedge clk);
      check({tag, "_errhold"}, {o_err, o_crn, o_trig}, 3'b100);
      check({tag, "_ntrig"}, trig_cnt - trig0, 0);
    end else begin
      check({tag, "_runst"}, {o_err, o_crn, o_done, o_busy, o_trig}, 5'b01101);
      if (mode == 0) check({tag, "_lat"}, t0, T_TRIG);
      @(negedge clk);
      check({tag, "_pulse"}, {o_trig, o_done, o_crn}, 3'b011);
      check({tag, "_ntrig"}, trig_cnt - trig0, 1);
    end
  endtask

  initial begin
    int         i;
    bit         hs;
    logic [7:0] old2;
    reset = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = 8'h00; sel = 1'b0; corrupt = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {o_ready, o_we, o_crn, o_trig, o_busy, o_done, o_err}, 7'b0);
    check("rst_addr", o_addr, 16'h0000);
    check("rst_din", o_din, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle", {o_crn, o_ready, o_busy, o_done, o_err}, 5'b0);

    img = '{8'hA9, 8'h05, 8'h69, 8'h03};
    run_load(0, 1'b0, "held");
    run_load(1, 1'b0, "gaps");
    rand_img();
    run_load(0, 1'b1, "start_in_load");
`ifdef PROG_LOADER_VERIFY_EN
    img     = '{8'hA9, 8'h05, 8'h69, 8'h03};
    corrupt = 1'b1;
    run_load(0, 1'b0, "corrupt");
    corrupt = 1'b0;
    run_load(0, 1'b0, "reload");
`endif

    // Reset after the second byte has been written.
    rand_img();
    img[0] = mem[BASE_A] ^ 8'hFF;
    img[1] = mem[BASE_A + 16'd1] ^ 8'hFF;
    old2   = mem[BASE_A + 16'd2];
    img[2] = old2 ^ 8'hFF;
    start = 1'b1; src_valid = 1'b1; src_data = img[0]; i = 0; hs = 1'b0;
    for (int k = 0; k < 20 && i < 2; k++) begin
      @(negedge clk);
      if (hs) i++;
      start    = 1'b0;
      src_data = img[i];
      hs       = src_valid && o_ready;
    end
    src_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ctrl", {o_ready, o_we, o_crn, o_trig, o_busy, o_done, o_err}, 7'b0);
    check("mid_rst_addr", o_addr, 16'h0000);
    check("mid_rst_din", o_din, 8'h00);
    check("mid_rst_mem0", mem[BASE_A], img[0]);
    check("mid_rst_mem1", mem[BASE_A + 16'd1], img[1]);
    check("mid_rst_mem2", mem[BASE_A + 16'd2], old2);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {o_crn, o_ready, o_busy}, 3'b0);
    rand_img();
    run_load(0, 1'b0, "post_rst");

    sel = 1'b1;
    rand_img();
    run_load(0, 1'b0, "wrap");
    rand_img();
    run_load(2, 1'b1, "wrap_rand");

    for (int r = 0; r < 8; r++) begin
      sel = 1'($urandom_range(0, 1));
      rand_img();
      run_load(2, 1'($urandom_range(0, 1)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
